// File: rtl/mod12_job_sched_pkg.sv
// Shared constants and FSM encoding for the mod-12 job scheduler.
// Imported by the counter core and the scheduler top.
package mod12_job_sched_pkg;

    localparam int MOD_DEF = 12;
    localparam int W_DEF   = 4;
    localparam int SW_DEF  = 4;

    localparam logic [W_DEF-1:0] MAX_VAL = W_DEF'(MOD_DEF - 1);
    localparam logic [W_DEF-1:0] ZERO    = '0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/mod12_job_sched_core.sv
// Loadable mod-MOD up/down counter with enable; load has priority.
// Ports: clk, rst (async high), load, en, dir (1=up), din -> value.
import mod12_job_sched_pkg::*;

module mod_updown_core #(
    parameter int MOD = MOD_DEF,
    parameter int W   = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic         dir,
    input  logic [W-1:0] din,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= din;
        end else if (en) begin
            if (dir)
                value <= (value == TOP) ? '0 : value + W'(1);
            else
                value <= (value == '0) ? TOP : value - W'(1);
        end
    end

endmodule

// File: rtl/mod12_job_sched.sv
// Round-robin job scheduler sharing one mod-MOD up/down counter.
// Ports: two job requesters (req/start/dir/steps), gnt, busy,
// cnt_val, done/done_id pulse, err pulse; clk, rst async high.
import mod12_job_sched_pkg::*;

module mod12_job_sched #(
    parameter int MOD = MOD_DEF,
    parameter int W   = W_DEF,
    parameter int SW  = SW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [W-1:0]  start0,
    input  logic          dir0,
    input  logic [SW-1:0] steps0,
    input  logic          req1,
    input  logic [W-1:0]  start1,
    input  logic          dir1,
    input  logic [SW-1:0] steps1,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic [W-1:0]  cnt_val,
    output logic          done,
    output logic          done_id,
    output logic          err
);

    state_t        state_q;
    logic          ptr_q;
    logic          id_q;
    logic [W-1:0]  start_q;
    logic          dir_q;
    logic [SW-1:0] steps_q;
    logic [SW-1:0] rem_q;

    logic win;
    logic bad_start;
    logic core_load;
    logic core_en;

    // ptr_q names the requester that wins a tie.
    always_comb begin
        win = 1'b0;
        if (req0 && req1)
            win = ptr_q;
        else
            win = req1;
    end

    assign bad_start = 32'(start_q) >= MOD;
    assign core_load = (state_q == ST_LOAD) && !bad_start;
    assign core_en   = (state_q == ST_RUN);

    mod_updown_core #(
        .MOD (MOD),
        .W   (W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (core_load),
        .en    (core_en),
        .dir   (dir_q),
        .din   (start_q),
        .value (cnt_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            start_q <= '0;
            dir_q   <= 1'b0;
            steps_q <= '0;
            rem_q   <= '0;
            gnt     <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            err     <= 1'b0;
        end else begin
            gnt     <= 2'b00;
            done    <= 1'b0;
            done_id <= 1'b0;
            err     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        id_q    <= win;
                        start_q <= win ? start1 : start0;
                        dir_q   <= win ? dir1 : dir0;
                        steps_q <= win ? steps1 : steps0;
                        gnt     <= win ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (bad_start) begin
                        err     <= 1'b1;
                        ptr_q   <= ~id_q;
                        busy    <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (steps_q != '0) begin
                        rem_q   <= steps_q;
                        state_q <= ST_RUN;
                    end else begin
                        rem_q   <= '0;
                        done    <= 1'b1;
                        done_id <= id_q;
                        state_q <= ST_DONE;
                    end
                end
                ST_RUN: begin
                    rem_q <= rem_q - SW'(1);
                    if (rem_q == SW'(1)) begin
                        done    <= 1'b1;
                        done_id <= id_q;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    ptr_q   <= ~id_q;
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod12_job_sched.sv
// Scoreboard bench for mod12_job_sched: directed jobs push
// expected grants/completions, a negedge monitor checks them.
module tb_mod12_job_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic [3:0] start0 = '0;
    logic       dir0 = 1'b0;
    logic [3:0] steps0 = '0;
    logic       req1 = 1'b0;
    logic [3:0] start1 = '0;
    logic       dir1 = 1'b0;
    logic [3:0] steps1 = '0;
    logic [1:0] gnt;
    logic       busy;
    logic [3:0] cnt_val;
    logic       done;
    logic       done_id;
    logic       err;

    typedef struct packed {
        logic       is_err;
        logic       id;
        logic [3:0] val;
    } ev_t;

    logic [1:0] exp_gnt[$];
    ev_t        exp_ev[$];

    int n_vec = 0;
    int n_bad = 0;

    mod12_job_sched dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .start0  (start0),
        .dir0    (dir0),
        .steps0  (steps0),
        .req1    (req1),
        .start1  (start1),
        .dir1    (dir1),
        .steps1  (steps1),
        .gnt     (gnt),
        .busy    (busy),
        .cnt_val (cnt_val),
        .done    (done),
        .done_id (done_id),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT presents an output.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != 2'b00) begin
                if (exp_gnt.size() == 0) begin
                    check("unexpected_gnt", int'(gnt), 0);
                end else begin
                    logic [1:0] g;
                    g = exp_gnt.pop_front();
                    check("gnt", int'(gnt), int'(g));
                end
            end
            if (done || err) begin
                if (exp_ev.size() == 0) begin
                    check("unexpected_done_err", int'({done, err}), 0);
                end else begin
                    ev_t e;
                    e = exp_ev.pop_front();
                    check("err_flag", int'(err), int'(e.is_err));
                    check("done_flag", int'(done), int'(!e.is_err));
                    if (done)
                        check("done_id", int'(done_id), int'(e.id));
                    check("final_cnt", int'(cnt_val), int'(e.val));
                end
            end
        end
    end

    task automatic set_job(input int id, input logic [3:0] s,
                           input logic d, input logic [3:0] n);
        if (id == 0) begin
            start0 = s; dir0 = d; steps0 = n;
        end else begin
            start1 = s; dir1 = d; steps1 = n;
        end
    endtask

    task automatic wait_gnt(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (gnt != 2'b00) begin
                g = gnt;
                break;
            end
        end
        if (g == 2'b00)
            check("gnt_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok)
            check("idle_timeout", 0, 1);
    endtask

    logic [1:0] g;
    logic [3:0] up_seq[4];
    logic [3:0] dn_seq[5];
    int         nbusy;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        up_seq = '{4'd10, 4'd11, 4'd0, 4'd1};
        dn_seq = '{4'd1, 4'd0, 4'd11, 4'd10, 4'd9};

        // Reset state
        #12;
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cnt", int'(cnt_val), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_id", int'(done_id), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Round-robin: both requesters keep asking
        set_job(0, 4'd2, 1'b1, 4'd1);
        set_job(1, 4'd7, 1'b0, 4'd2);
        for (int i = 0; i < 2; i++) begin
            exp_gnt.push_back(2'b01);
            exp_ev.push_back('{1'b0, 1'b0, 4'd3});
            exp_gnt.push_back(2'b10);
            exp_ev.push_back('{1'b0, 1'b1, 4'd5});
        end
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g);
            if (i == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (g[0]) req0 = 1'b0;
                if (g[1]) req1 = 1'b0;
                @(posedge clk); #1;
                req0 = 1'b1; req1 = 1'b1;
            end
        end
        wait_idle();

        // Up job wrapping MOD-1 -> 0
        set_job(0, 4'd10, 1'b1, 4'd3);
        exp_gnt.push_back(2'b01);
        exp_ev.push_back('{1'b0, 1'b0, 4'd1});
        req0 = 1'b1;
        wait_gnt(g);
        req0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("up_seq", int'(cnt_val), int'(up_seq[i]));
        end
        check("up_done_latency", int'(done), 1);
        wait_idle();

        // Down job wrapping 0 -> MOD-1
        set_job(1, 4'd1, 1'b0, 4'd4);
        exp_gnt.push_back(2'b10);
        exp_ev.push_back('{1'b0, 1'b1, 4'd9});
        req1 = 1'b1;
        wait_gnt(g);
        req1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("dn_seq", int'(cnt_val), int'(dn_seq[i]));
        end
        check("dn_done_latency", int'(done), 1);
        wait_idle();

        // Illegal start: err, counter untouched at 9
        set_job(0, 4'd12, 1'b1, 4'd2);
        exp_gnt.push_back(2'b01);
        exp_ev.push_back('{1'b1, 1'b0, 4'd9});
        req0 = 1'b1;
        wait_gnt(g);
        req0 = 1'b0;
        wait_idle();

        // Tie now goes to requester 1; zero-step job
        set_job(0, 4'd4, 1'b1, 4'd2);
        set_job(1, 4'd5, 1'b1, 4'd0);
        exp_gnt.push_back(2'b10);
        exp_ev.push_back('{1'b0, 1'b1, 4'd5});
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(g);
        req0 = 1'b0; req1 = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            nbusy++;
            @(posedge clk); #1;
        end
        check("zero_steps_busy_cycles", nbusy, 2);

        // Reset in the middle of a long job
        set_job(0, 4'd0, 1'b1, 4'd8);
        exp_gnt.push_back(2'b01);
        req0 = 1'b1;
        wait_gnt(g);
        req0 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_gnt", int'(gnt), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_cnt", int'(cnt_val), 0);
        check("arst_done", int'(done), 0);
        check("arst_err", int'(err), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        set_job(0, 4'd3, 1'b1, 4'd1);
        exp_gnt.push_back(2'b01);
        exp_ev.push_back('{1'b0, 1'b0, 4'd4});
        req0 = 1'b1;
        wait_gnt(g);
        req0 = 1'b0;
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        check("gnt_queue_drained", exp_gnt.size(), 0);
        check("ev_queue_drained", exp_ev.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mod12_job_sched.md
Name: mod12_job_sched

Overview:
Shares one loadable mod-MOD up/down counter core between two requesters. Each requester submits a job: start value, direction and step count. The scheduler arbitrates round-robin, loads the core, runs it for the requested number of steps, then reports the final value with a one-cycle done pulse. It is the sequencing layer above the mod-12 loadable up/down counter in the timer/counting datapath.

Parameters:
MOD, 12, counter modulus; legal values are 0..MOD-1.
W, 4, counter value width; must satisfy 2^W >= MOD.
SW, 4, step-count width.

Ports:
clk      input   1   clock; all state updates on the rising edge.
rst      input   1   reset; asynchronous, active-high.
req0     input   1   job request, requester 0; held until gnt[0].
start0   input   W   start value, requester 0.
dir0     input   1   direction, requester 0; 1 = up, 0 = down.
steps0   input   SW  steps to count, requester 0.
req1     input   1   job request, requester 1.
start1   input   W   start value, requester 1.
dir1     input   1   direction, requester 1.
steps1   input   SW  steps to count, requester 1.
gnt      output  2   one-hot grant pulse, one cycle.
busy     output  1   high whenever state != IDLE.
cnt_val  output  W   current core value.
done     output  1   one-cycle pulse; job complete.
done_id  output  1   requester served; valid while done=1.
err      output  1   one-cycle pulse; job rejected.

Behaviour:
- Reset (async, active-high), effective immediately regardless of clk:
  - state = IDLE; gnt, busy, done, done_id, err = 0; cnt_val = 0.
  - Round-robin pointer favours req0.
  - Reset mid-job aborts the job: no done, no err.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Samples req0/req1 at each edge.
  - If any request is high: the winner is the sole requester, or the pointer's favourite if both are high.
  - Latch start, dir, steps and id from the winner. Go to LOAD.
  - gnt[id] = 1 for the LOAD cycle only.
- Requester handshake: the requester drops req in the cycle it sees gnt. req is not sampled outside IDLE.
- LOAD:
  - If latched start >= MOD: err = 1 for one cycle, core untouched, return to IDLE, pointer moves to the other requester.
  - Otherwise assert core load. cnt_val = start on the next edge. remaining = steps.
  - Next state is RUN if steps != 0, else DONE.
- RUN:
  - Core enabled with the latched dir. Each edge: value +/-1 mod MOD, remaining -1.
  - Up count wraps MOD-1 -> 0. Down count wraps 0 -> MOD-1.
  - After exactly `steps` RUN cycles, go to DONE.
- DONE:
  - done = 1 and done_id = id for one cycle; cnt_val holds the final value.
  - Pointer moves to the other requester. Return to IDLE.
- Latency: req sampled at edge k -> gnt high in cycle k+1 -> done high in cycle k+2+steps.
- cnt_val holds its value in IDLE; the core is neither loaded nor enabled.
- Jobs are never preempted; a request arriving while busy waits.

Decomposition:
- Shared package: state enum (IDLE/LOAD/RUN/DONE), MOD-derived constants MAX_VAL = MOD-1 and ZERO.
- One sub-module, mod_updown_core: loadable mod-MOD up/down counter with enable. Inputs: load, en, dir, din. Output: value. Asynchronous active-high reset to 0.
- Arbiter pointer and FSM stay in mod_updown_core's parent (this block).

Test Plan:
- Up job with wrap: req0, start0=10, dir0=1, steps0=3 -> gnt=01 one cycle; cnt_val 10, 11, 0, 1; done=1, done_id=0, cnt_val=1 four cycles after gnt.
- Down job with wrap: req1, start1=1, dir1=0, steps1=4 -> cnt_val 1, 0, 11, 10, 9; done=1, done_id=1, cnt_val=9.
- Round-robin: after reset, req0 and req1 high together and reasserted after each grant -> grant order gnt=01, 10, 01, 10; each done_id matches its grant.
- Illegal start: start0=12, steps0=2 -> gnt=01, then err=1 for one cycle; no done; cnt_val unchanged; next simultaneous request grants requester 1.
- Zero steps: start1=5, steps1=0 -> gnt=10, cnt_val=5, done=1 in the cycle after LOAD; busy high for exactly 2 cycles.
- Reset mid-RUN: assert rst asynchronously during a steps=8 job -> all outputs 0 at once with no clk edge, no done. After release, req0 with start0=3, steps0=1 completes with cnt_val=4 (dir0=1).
